// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath: operand-fetch FSM states and
// the RAM-slot selector encoding.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } opf_state_t;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/opf_lat_cnt.sv
// Loadable down-counter timing the RAM read latency; zero_o marks the
// cycle in which read data is valid at the RAM output.
module opf_lat_cnt #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    localparam int CW = $clog2(RD_LAT + 1);
    localparam logic [CW-1:0] LOAD_V = CW'(RD_LAT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = LOAD_V;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/operand_fetch.sv
// Registered operand fetch: latches two operands from direct inputs or RAM
// and presents them under valid/ack. Optional OPERAND_FETCH_SWAP_EN adds a swap input.
module operand_fetch
    import calc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rd_en,
    input  logic              rd_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  num_a,
    input  logic [WIDTH-1:0]  num_b,
`ifdef OPERAND_FETCH_SWAP_EN
    input  logic              swap,
`endif
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [WIDTH-1:0]  ram_rdata,
    output logic              ready,
    output logic              valid,
    input  logic              ack,
    output logic [WIDTH-1:0]  operand_a,
    output logic [WIDTH-1:0]  operand_b
);

    opf_state_t        state_q, state_d;
    logic [WIDTH-1:0]  na_q, na_d, nb_q, nb_d;
    logic [WIDTH-1:0]  opa_q, opa_d, opb_q, opb_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              sel_q, sel_d;
    logic              swap_q, swap_d;
    logic              swap_s;
    logic              accept;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [WIDTH-1:0]  cap_a, cap_b;

`ifdef OPERAND_FETCH_SWAP_EN
    assign swap_s = swap;
`else
    assign swap_s = 1'b0;
`endif

    opf_lat_cnt #(.RD_LAT(RD_LAT)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .load_i (cnt_load),
        .dec_i  (cnt_dec),
        .zero_o (cnt_zero)
    );

    // RAM data lands in the selected slot; the other keeps its staged direct value
    assign cap_a = (sel_q == SEL_A) ? ram_rdata : na_q;
    assign cap_b = (sel_q == SEL_B) ? ram_rdata : nb_q;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE && ack));

    always_comb begin
        state_d  = state_q;
        na_d     = na_q;
        nb_d     = nb_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        addr_d   = addr_q;
        sel_d    = sel_q;
        swap_d   = swap_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        case (state_q)
            REQ: begin
                cnt_load = 1'b1;
                state_d  = WAIT;
            end
            WAIT: begin
                if (cnt_zero) begin
                    opa_d   = swap_q ? cap_b : cap_a;
                    opb_d   = swap_q ? cap_a : cap_b;
                    state_d = DONE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            DONE: begin
                if (ack)
                    state_d = IDLE;
            end
            default: ;
        endcase

        // A new request from DONE+ack overrides the return to IDLE
        if (accept) begin
            if (rd_en) begin
                na_d    = num_a;
                nb_d    = num_b;
                addr_d  = addr;
                sel_d   = rd_sel;
                swap_d  = swap_s;
                state_d = REQ;
            end else begin
                opa_d   = swap_s ? num_b : num_a;
                opb_d   = swap_s ? num_a : num_b;
                state_d = DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            na_q    <= '0;
            nb_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            addr_q  <= '0;
            sel_q   <= SEL_A;
            swap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            na_q    <= na_d;
            nb_q    <= nb_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            addr_q  <= addr_d;
            sel_q   <= sel_d;
            swap_q  <= swap_d;
        end
    end

    assign ram_re    = (state_q == REQ);
    assign ram_addr  = addr_q;
    assign ready     = (state_q == IDLE);
    assign valid     = (state_q == DONE);
    assign operand_a = opa_q;
    assign operand_b = opb_q;

endmodule
